b1_resp_misr: RTL and testbench

Downstream response compactor for the b1 combinational benchmark stage. It accepts b1's 4-bit output vector (po3..po0) through a valid/ready handshake and folds each accepted vector into a Galois MISR signature. It counts accepted vectors and stops after a programmed number. A sequencing FSM gives the test harness start/busy/done control around the compaction run.

---
 rtl/b1_resp_misr.sv | 113 +++++++++++
 tb/tb_b1_resp_misr.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/b1_resp_misr.sv
// Response compactor for the b1 stage: folds accepted 4-bit vectors into a Galois MISR.
// Optional macro B1_RESP_CHECK_EN adds a sticky err output for po0 == po3 violations.
module b1_resp_misr #(
   parameter int          SIG_W = 16,
   parameter int          CNT_W = 8,
   parameter logic [15:0] POLY  = 16'h6801,
   parameter logic [15:0] SEED  = 16'hFFFF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_po,
   output logic             busy,
   output logic             done,
`ifdef B1_RESP_CHECK_EN
   output logic             err,
`endif
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] vec_count
);

   localparam logic [SIG_W-1:0] L_POLY = SIG_W'(POLY);
   localparam logic [SIG_W-1:0] L_SEED = SIG_W'(SEED);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [SIG_W-1:0] r_sig;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_target;
   logic             w_accept;
   logic             w_start_ok;
   logic             w_last;
   logic [SIG_W-1:0] w_sig_next;

   assign w_accept   = in_valid & in_ready;
   assign w_start_ok = start & (r_state != RUN);
   assign w_last     = (r_cnt == CNT_W'(r_target - 1'b1));

   // Left-shift Galois step with the vector injected into the low bits.
   assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                     ^ (r_sig[SIG_W-1] ? L_POLY : '0)
                     ^ SIG_W'(in_po);

   // NOTE: state and datapath registers use non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: w_next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE, DONE: if (start) w_next_state = (num_vec == '0) ? DONE : RUN;
         RUN:        if (w_accept && w_last) w_next_state = DONE;
         default:    w_next_state = IDLE;
      endcase
   end

   // Outputs decode the state register only, so in_ready has no path from in_valid.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         RUN:     begin in_ready = 1'b1; busy = 1'b1; end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sig    <= L_SEED;
         r_cnt    <= '0;
         r_target <= '0;
      end else if (w_start_ok) begin
         r_sig    <= L_SEED;
         r_cnt    <= '0;
         r_target <= num_vec;
      end else if (w_accept) begin
         r_sig    <= w_sig_next;
         r_cnt    <= r_cnt + 1'b1;
      end
   end

`ifdef B1_RESP_CHECK_EN
   logic r_err;

   always_ff @(posedge clock) begin
      if (reset)                             r_err <= 1'b0;
      else if (w_start_ok)                   r_err <= 1'b0;
      else if (w_accept && (in_po[0] == in_po[3])) r_err <= 1'b1;
   end

   assign err = r_err;
`endif

   assign signature = r_sig;
   assign vec_count = r_cnt;

endmodule

// File: tb/tb_b1_resp_misr.sv
// Directed self-checking bench for b1_resp_misr (covers B1_RESP_CHECK_EN when defined).
module tb_b1_resp_misr;

   localparam int SIG_W = 16;
   localparam int CNT_W = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_vec = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       in_po = '0;
   logic             busy;
   logic             done;
   logic [SIG_W-1:0] signature;
   logic [CNT_W-1:0] vec_count;
`ifdef B1_RESP_CHECK_EN
   logic             err;
`endif

   int checks = 0;
   int errors = 0;

   // Observed tuple {in_ready, busy, done, signature, vec_count}
   logic [26:0] w_obs;
   assign w_obs = {in_ready, busy, done, signature, vec_count};

   b1_resp_misr dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .num_vec   (num_vec),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_po     (in_po),
      .busy      (busy),
      .done      (done),
`ifdef B1_RESP_CHECK_EN
      .err       (err),
`endif
      .signature (signature),
      .vec_count (vec_count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [26:0] exp_t(input logic rdy, input logic bsy, input logic dn,
                                         input logic [15:0] sig, input logic [7:0] cnt);
      return {rdy, bsy, dn, sig, cnt};
   endfunction

   // Independent reference for long runs: one MISR step from the polynomial definition.
   function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [3:0] v);
      logic [15:0] t;
      t = s << 1;
      if (s[15]) t = t ^ 16'h6801;
      return t ^ {12'h000, v};
   endfunction

   task automatic do_start(input logic [CNT_W-1:0] n);
      start   = 1'b1;
      num_vec = n;
      step();
      start   = 1'b0;
   endtask

   task automatic accept(input logic [3:0] v);
      in_valid = 1'b1;
      in_po    = v;
      step();
      in_valid = 1'b0;
      in_po    = 4'hx;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (w_obs !== exp_t(0, 0, 0, 16'hFFFF, 8'd0)) begin
            $display("FAIL reset_idle cyc%0d got %h want %h", i, w_obs, exp_t(0, 0, 0, 16'hFFFF, 8'd0));
            errors++;
         end
         step();
      end
   endtask

   task automatic test_single();
      do_start(8'd1);
      checks++;
      if (w_obs !== exp_t(1, 1, 0, 16'hFFFF, 8'd0)) begin
         $display("FAIL single_run got %h want %h", w_obs, exp_t(1, 1, 0, 16'hFFFF, 8'd0));
         errors++;
      end
      accept(4'b0101);
      checks++;
      if (w_obs !== exp_t(0, 0, 1, 16'h97FA, 8'd1)) begin
         $display("FAIL single_done got %h want %h", w_obs, exp_t(0, 0, 1, 16'h97FA, 8'd1));
         errors++;
      end
   endtask

   task automatic test_gap_and_ignored_start();
      do_start(8'd2);
      accept(4'b0101);
      checks++;
      if (w_obs !== exp_t(1, 1, 0, 16'h97FA, 8'd1)) begin
         $display("FAIL gap_first got %h want %h", w_obs, exp_t(1, 1, 0, 16'h97FA, 8'd1));
         errors++;
      end
      // start pulsed in RUN with a different count must be ignored
      start   = 1'b1;
      num_vec = 8'd7;
      for (int i = 0; i < 3; i++) begin
         step();
         start = 1'b0;
         checks++;
         if (w_obs !== exp_t(1, 1, 0, 16'h97FA, 8'd1)) begin
            $display("FAIL gap_hold cyc%0d got %h want %h", i, w_obs, exp_t(1, 1, 0, 16'h97FA, 8'd1));
            errors++;
         end
      end
      accept(4'b1010);
      checks++;
      if (w_obs !== exp_t(0, 0, 1, 16'h47FF, 8'd2)) begin
         $display("FAIL gap_final got %h want %h", w_obs, exp_t(0, 0, 1, 16'h47FF, 8'd2));
         errors++;
      end
      // valid in DONE is dropped; result holds
      accept(4'b0011);
      step();
      checks++;
      if (w_obs !== exp_t(0, 0, 1, 16'h47FF, 8'd2)) begin
         $display("FAIL done_hold got %h want %h", w_obs, exp_t(0, 0, 1, 16'h47FF, 8'd2));
         errors++;
      end
   endtask

   task automatic test_zero_vectors();
      in_valid = 1'b1;
      in_po    = 4'b0110;
      do_start(8'd0);
      checks++;
      if (w_obs !== exp_t(0, 0, 1, 16'hFFFF, 8'd0)) begin
         $display("FAIL zero_run got %h want %h", w_obs, exp_t(0, 0, 1, 16'hFFFF, 8'd0));
         errors++;
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (w_obs !== exp_t(0, 0, 1, 16'hFFFF, 8'd0)) begin
         $display("FAIL zero_hold got %h want %h", w_obs, exp_t(0, 0, 1, 16'hFFFF, 8'd0));
         errors++;
      end
   endtask

   task automatic test_reset_mid_run();
      do_start(8'd4);
      accept(4'b0101);
      accept(4'b1010);
      checks++;
      if (w_obs !== exp_t(1, 1, 0, 16'h47FF, 8'd2)) begin
         $display("FAIL mid_before got %h want %h", w_obs, exp_t(1, 1, 0, 16'h47FF, 8'd2));
         errors++;
      end
      // reset wins over simultaneous start and valid
      reset    = 1'b1;
      start    = 1'b1;
      num_vec  = 8'd3;
      in_valid = 1'b1;
      in_po    = 4'b1111;
      step();
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (w_obs !== exp_t(0, 0, 0, 16'hFFFF, 8'd0)) begin
         $display("FAIL mid_reset got %h want %h", w_obs, exp_t(0, 0, 0, 16'hFFFF, 8'd0));
         errors++;
      end
      do_start(8'd1);
      accept(4'b0101);
      checks++;
      if (w_obs !== exp_t(0, 0, 1, 16'h97FA, 8'd1)) begin
         $display("FAIL mid_rerun got %h want %h", w_obs, exp_t(0, 0, 1, 16'h97FA, 8'd1));
         errors++;
      end
   endtask

   task automatic test_max_run();
      logic [15:0] exp_sig;
      logic [3:0]  v;
      exp_sig = 16'hFFFF;
      do_start(8'd255);
      in_valid = 1'b1;
      for (int i = 0; i < 255; i++) begin
         v       = 4'(i * 7 + 3);
         in_po   = v;
         exp_sig = ref_step(exp_sig, v);
         step();
         if (i == 253) begin
            checks++;
            if (w_obs !== exp_t(1, 1, 0, exp_sig, 8'd254)) begin
               $display("FAIL max_penult got %h want %h", w_obs, exp_t(1, 1, 0, exp_sig, 8'd254));
               errors++;
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (w_obs !== exp_t(0, 0, 1, exp_sig, 8'd255)) begin
         $display("FAIL max_final got %h want %h", w_obs, exp_t(0, 0, 1, exp_sig, 8'd255));
         errors++;
      end
   endtask

`ifdef B1_RESP_CHECK_EN
   task automatic test_err();
      do_start(8'd2);
      accept(4'b1001);
      checks++;
      if (err !== 1'b1) begin
         $display("FAIL err_set got %b want 1", err);
         errors++;
      end
      accept(4'b0101);
      checks++;
      if ({err, done, signature} !== {1'b1, 1'b1, ref_step(ref_step(16'hFFFF, 4'b1001), 4'b0101)}) begin
         $display("FAIL err_done got %b/%b/%h want sticky err in DONE", err, done, signature);
         errors++;
      end
      do_start(8'd1);
      checks++;
      if (err !== 1'b0) begin
         $display("FAIL err_clear got %b want 0", err);
         errors++;
      end
      accept(4'b0101);
      checks++;
      if ({err, done, signature} !== {1'b0, 1'b1, 16'h97FA}) begin
         $display("FAIL err_clean got %b/%b/%h want 0/1/97fa", err, done, signature);
         errors++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_gap_and_ignored_start();
      test_zero_vectors();
      test_reset_mid_run();
      test_max_run();
`ifdef B1_RESP_CHECK_EN
      test_err();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
